// File: rtl/vga_pkg.sv
// rtl/vga_pkg.sv - shared VGA timing constants and scheduler state encoding
// Purpose : constants common to the video blocks plus the scheduler FSM states.
// Ports   : none (package).
package vga_pkg;

  localparam int H_DISPLAY = 640;
  localparam int H_TOTAL   = 800;
  localparam int V_DISPLAY = 480;
  localparam int V_TOTAL   = 525;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_OWN  = 1'b1
  } sched_state_t;

endpackage

// File: rtl/vga_mem_scheduler_if.sv
// rtl/vga_mem_scheduler_if.sv - requester, display fetch and RAM port bundle
// Purpose : groups the requester/display inputs and the RAM-side outputs of the scheduler.
// Signals : req/req_we/req_addr/req_wdata (packed per requester), disp_req/disp_addr,
//           gnt/owner_valid, mem_en/mem_we/mem_addr/mem_wdata.
// Modports: master drives requests and observes grants/RAM port; slave is the scheduler.
interface vga_mem_scheduler_if #(
  parameter int N_REQ  = 3,
  parameter int ADDR_W = 12,
  parameter int DATA_W = 8
);

  logic [N_REQ-1:0]        req;
  logic [N_REQ-1:0]        req_we;
  logic [N_REQ*ADDR_W-1:0] req_addr;
  logic [N_REQ*DATA_W-1:0] req_wdata;
  logic                    disp_req;
  logic [ADDR_W-1:0]       disp_addr;
  logic [N_REQ-1:0]        gnt;
  logic                    owner_valid;
  logic                    mem_en;
  logic                    mem_we;
  logic [ADDR_W-1:0]       mem_addr;
  logic [DATA_W-1:0]       mem_wdata;

  modport master (
    output req, req_we, req_addr, req_wdata, disp_req, disp_addr,
    input  gnt, owner_valid, mem_en, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    input  req, req_we, req_addr, req_wdata, disp_req, disp_addr,
    output gnt, owner_valid, mem_en, mem_we, mem_addr, mem_wdata
  );

endinterface

// File: rtl/vga_rr_pick.sv
// rtl/vga_rr_pick.sv - combinational round-robin priority encoder
// Purpose : returns the first set req bit searching rr_ptr, rr_ptr+1, ... modulo N.
// Ports   : req (N), rr_ptr (IDX_W) in; idx (IDX_W), any (1) out.
module vga_rr_pick #(
  parameter int N     = 3,
  parameter int IDX_W = 2
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] rr_ptr,
  output logic [IDX_W-1:0] idx,
  output logic             any
);

  // One extra bit so rr_ptr + k never overflows before the modulo fold.
  logic [IDX_W:0] cand;
  logic           found;

  always_comb begin
    idx   = '0;
    found = 1'b0;
    cand  = '0;
    for (int k = 0; k < N; k++) begin
      cand = {1'b0, rr_ptr} + (IDX_W+1)'(k);
      if (cand >= (IDX_W+1)'(N)) begin
        cand = cand - (IDX_W+1)'(N);
      end
      if (!found && req[cand[IDX_W-1:0]]) begin
        found = 1'b1;
        idx   = cand[IDX_W-1:0];
      end
    end
  end

  assign any = |req;

endmodule

// File: rtl/vga_mem_scheduler.sv
// rtl/vga_mem_scheduler.sv - single-port video RAM scheduler (display + round-robin requesters)
// Purpose : display fetch always wins the RAM; requesters own the port round-robin in
//           bursts of up to BURST_MAX beats, optionally only during blanking. Also
//           produces the vblank_start pulse and a wrapping frame counter.
// Ports   : clk, rst_n (async, active low); x, y, active from vga_timing;
//           bus (slave modport: requests, display fetch, grants, RAM port);
//           vblank_start (1-cycle pulse after x==0,y==480), frame_cnt (16).
module vga_mem_scheduler
  import vga_pkg::*;
#(
  parameter int N_REQ      = 3,
  parameter int ADDR_W     = 12,
  parameter int DATA_W     = 8,
  parameter int BURST_MAX  = 16,
  parameter int BLANK_ONLY = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [9:0]          x,
  input  logic [9:0]          y,
  input  logic                active,
  vga_mem_scheduler_if.slave  bus,
  output logic                vblank_start,
  output logic [15:0]         frame_cnt
);

  localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int CNT_W = $clog2(BURST_MAX + 1);

  sched_state_t     state, state_n;
  logic [IDX_W-1:0] owner, owner_n;
  logic [IDX_W-1:0] rr_ptr, rr_ptr_n;
  logic [IDX_W-1:0] owner_inc;
  logic [IDX_W-1:0] pick_idx;
  logic [CNT_W-1:0] burst_cnt, burst_cnt_n;
  logic             pick_any;
  logic             own_req;
  logic             blank_ok;
  logic             disp_go;
  logic             beat;

  vga_rr_pick #(
    .N     (N_REQ),
    .IDX_W (IDX_W)
  ) u_pick (
    .req    (bus.req),
    .rr_ptr (rr_ptr),
    .idx    (pick_idx),
    .any    (pick_any)
  );

  assign own_req  = bus.req[owner];
  assign blank_ok = (BLANK_ONLY == 0) || !active;
  // Display path is gated by reset so every output reads 0 while rst_n is low.
  assign disp_go  = bus.disp_req && rst_n;
  // Ownership alone is not an access: the display steals the cycle and, when
  // confined to blanking, the visible region freezes the burst mid-way.
  assign beat      = (state == ST_OWN) && own_req && !disp_go && blank_ok;
  assign owner_inc = (owner == IDX_W'(N_REQ - 1)) ? '0 : owner + 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      owner     <= '0;
      rr_ptr    <= '0;
      burst_cnt <= '0;
    end else begin
      state     <= state_n;
      owner     <= owner_n;
      rr_ptr    <= rr_ptr_n;
      burst_cnt <= burst_cnt_n;
    end
  end

  always_comb begin
    state_n     = state;
    owner_n     = owner;
    rr_ptr_n    = rr_ptr;
    burst_cnt_n = burst_cnt;
    case (state)
      ST_IDLE: begin
        if (pick_any) begin
          state_n     = ST_OWN;
          owner_n     = pick_idx;
          burst_cnt_n = '0;
        end
      end
      ST_OWN: begin
        // Release on dropped request or on the final beat; the pointer moves past
        // the releasing owner so waiting lower-priority requesters go next.
        if (!own_req || (beat && burst_cnt == CNT_W'(BURST_MAX - 1))) begin
          state_n     = ST_IDLE;
          rr_ptr_n    = owner_inc;
          burst_cnt_n = '0;
        end else if (beat) begin
          burst_cnt_n = burst_cnt + 1'b1;
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

  always_comb begin
    bus.gnt        = '0;
    bus.gnt[owner] = beat;
    bus.owner_valid = (state == ST_OWN);
    bus.mem_en     = 1'b0;
    bus.mem_we     = 1'b0;
    bus.mem_addr   = '0;
    bus.mem_wdata  = '0;
    if (disp_go) begin
      bus.mem_en   = 1'b1;
      bus.mem_addr = bus.disp_addr;
    end else if (beat) begin
      bus.mem_en    = 1'b1;
      bus.mem_we    = bus.req_we[owner];
      bus.mem_addr  = bus.req_addr[owner*ADDR_W +: ADDR_W];
      bus.mem_wdata = bus.req_wdata[owner*DATA_W +: DATA_W];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vblank_start <= 1'b0;
      frame_cnt    <= '0;
    end else begin
      vblank_start <= (x == 10'd0) && (y == 10'(V_DISPLAY));
      if ((x == 10'd0) && (y == 10'(V_DISPLAY))) begin
        frame_cnt <= frame_cnt + 16'd1;
      end
    end
  end

endmodule
